// File: rtl/control_sequencer_pkg.sv
// Shared opcodes, ALU operation codes, sequencer states and the decoded control bundle
// for the fetch/decode/PC sequencer.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [5:0] ALU_NONE = 6'd0;
  localparam logic [5:0] ALU_ADD  = 6'd1;
  localparam logic [5:0] ALU_SUB  = 6'd2;
  localparam logic [5:0] ALU_AND  = 6'd3;
  localparam logic [5:0] ALU_OR   = 6'd4;
  localparam logic [5:0] ALU_XOR  = 6'd5;
  localparam logic [5:0] ALU_SLL  = 6'd6;
  localparam logic [5:0] ALU_SRL  = 6'd7;
  localparam logic [5:0] ALU_SRA  = 6'd8;
  localparam logic [5:0] ALU_SLT  = 6'd9;
  localparam logic [5:0] ALU_ADDI = 6'd10;
  localparam logic [5:0] ALU_EQ   = 6'd20;
  localparam logic [5:0] ALU_NE   = 6'd21;
  localparam logic [5:0] ALU_LT   = 6'd22;
  localparam logic [5:0] ALU_GE   = 6'd23;

  typedef enum logic [1:0] {StFetch, StDecode, StExec, StTrap} state_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [5:0]  alu;
    logic [31:0] imm;
    logic [3:0]  shamt;
    logic [31:0] imm_lui;
    logic [31:0] imm_jump;
    logic [31:0] imm_branch;
    logic        lb;
    logic        sw;
    logic        lui;
    logic        jump;
    logic        beq;
    logic        bne;
    logic        bge;
    logic        blt;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and imem (slave).
interface control_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_instr;

  modport master (output imem_req, output imem_addr, input imem_valid, input imem_instr);
  modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_instr);
endinterface

// File: rtl/control_sequencer_decoder.sv
// Combinational RV32I-subset decoder: one instruction word in, control bundle and
// an illegal flag out.
module instr_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign alt    = instr_i[30];  // funct7[5]: sub / sra selector

  always_comb begin
    ctrl_o            = '0;
    illegal_o         = 1'b0;
    ctrl_o.rs1        = instr_i[19:15];
    ctrl_o.rs2        = instr_i[24:20];
    ctrl_o.rd         = instr_i[11:7];
    ctrl_o.shamt      = instr_i[23:20];
    ctrl_o.imm        = {{20{instr_i[31]}}, instr_i[31:20]};
    ctrl_o.imm_lui    = {instr_i[31:12], 12'b0};
    ctrl_o.imm_jump   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
    ctrl_o.imm_branch = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};

    case (opcode)
      OPC_RTYPE: begin
        case (funct3)
          3'b000:  ctrl_o.alu = alt ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl_o.alu = ALU_SLL;
          3'b010:  ctrl_o.alu = ALU_SLT;
          3'b100:  ctrl_o.alu = ALU_XOR;
          3'b101:  ctrl_o.alu = alt ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl_o.alu = ALU_OR;
          3'b111:  ctrl_o.alu = ALU_AND;
          default: illegal_o  = 1'b1;
        endcase
      end
      OPC_IALU: begin
        case (funct3)
          3'b000:  ctrl_o.alu = ALU_ADDI;
          3'b001:  ctrl_o.alu = ALU_SLL;
          3'b100:  ctrl_o.alu = ALU_XOR;
          3'b101:  ctrl_o.alu = alt ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl_o.alu = ALU_OR;
          3'b111:  ctrl_o.alu = ALU_AND;
          default: illegal_o  = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        if (funct3 == 3'b000) begin
          ctrl_o.lb  = 1'b1;
          ctrl_o.alu = ALU_ADD;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b010) begin
          ctrl_o.sw  = 1'b1;
          ctrl_o.alu = ALU_ADD;
          ctrl_o.imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000:  begin ctrl_o.beq = 1'b1; ctrl_o.alu = ALU_EQ; end
          3'b001:  begin ctrl_o.bne = 1'b1; ctrl_o.alu = ALU_NE; end
          3'b100:  begin ctrl_o.blt = 1'b1; ctrl_o.alu = ALU_LT; end
          3'b101:  begin ctrl_o.bge = 1'b1; ctrl_o.alu = ALU_GE; end
          default: illegal_o = 1'b1;
        endcase
      end
      OPC_LUI: ctrl_o.lui  = 1'b1;
      OPC_JAL: ctrl_o.jump = 1'b1;
      default: illegal_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer: fetches from imem, registers decoded controls
// for the data path, and resolves the next PC from the data-path branch flags.
module control_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                 clk,
  input  logic                 rst,
  control_sequencer_if.master  imem,
  output logic [4:0]           read_reg_num1,
  output logic [4:0]           read_reg_num2,
  output logic [4:0]           write_reg_num1,
  output logic [5:0]           alu_control,
  output logic [31:0]          imm_val,
  output logic [3:0]           shamt,
  output logic                 lb,
  output logic                 sw,
  output logic                 lui_control,
  output logic                 jump,
  output logic                 beq_control,
  output logic                 bne_control,
  output logic                 bgeq_control,
  output logic                 blt_control,
  output logic [31:0]          imm_val_lui,
  output logic [31:0]          imm_val_jump,
  output logic [31:0]          return_address,
  input  logic                 beq,
  input  logic                 bneq,
  input  logic                 bge,
  input  logic                 blt,
  output logic [31:0]          pc,
  output logic                 illegal
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        illegal_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [4:0]  rd_q;
  logic [5:0]  alu_q;
  logic [31:0] imm_q;
  logic [3:0]  shamt_q;
  logic [31:0] imm_lui_q;
  logic [31:0] imm_jump_q;
  logic [31:0] imm_branch_q;
  logic [31:0] ret_q;
  logic        lb_q;
  logic        sw_q;
  logic        lui_q;
  logic        jump_q;
  logic        beq_q;
  logic        bne_q;
  logic        bge_q;
  logic        blt_q;

  ctrl_t       dec;
  logic        dec_illegal;
  logic        taken;
  logic [31:0] pc_next;

  instr_decoder u_decoder (
    .instr_i   (instr_q),
    .ctrl_o    (dec),
    .illegal_o (dec_illegal)
  );

  // Qualifiers are one-hot, so each flag only counts alongside its own qualifier.
  always_comb begin
    taken = (beq_q & beq) | (bne_q & bneq) | (bge_q & bge) | (blt_q & blt);
    if (jump_q) begin
      pc_next = pc_q + imm_jump_q;
    end else if (taken) begin
      pc_next = pc_q + imm_branch_q;
    end else begin
      pc_next = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      illegal_q    <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      alu_q        <= '0;
      imm_q        <= '0;
      shamt_q      <= '0;
      imm_lui_q    <= '0;
      imm_jump_q   <= '0;
      imm_branch_q <= '0;
      ret_q        <= '0;
      lb_q         <= 1'b0;
      sw_q         <= 1'b0;
      lui_q        <= 1'b0;
      jump_q       <= 1'b0;
      beq_q        <= 1'b0;
      bne_q        <= 1'b0;
      bge_q        <= 1'b0;
      blt_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem.imem_valid) begin
            instr_q <= imem.imem_instr;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          rs1_q        <= dec.rs1;
          rs2_q        <= dec.rs2;
          rd_q         <= dec.rd;
          alu_q        <= dec.alu;
          imm_q        <= dec.imm;
          shamt_q      <= dec.shamt;
          imm_lui_q    <= dec.imm_lui;
          imm_jump_q   <= dec.imm_jump;
          imm_branch_q <= dec.imm_branch;
          ret_q        <= pc_q + PC_STEP;
          if (dec_illegal) begin
            illegal_q <= 1'b1;
            state_q   <= StTrap;
          end else begin
            lb_q    <= dec.lb;
            sw_q    <= dec.sw;
            lui_q   <= dec.lui;
            jump_q  <= dec.jump;
            beq_q   <= dec.beq;
            bne_q   <= dec.bne;
            bge_q   <= dec.bge;
            blt_q   <= dec.blt;
            state_q <= StExec;
          end
        end
        StExec: begin
          pc_q    <= pc_next;
          lb_q    <= 1'b0;
          sw_q    <= 1'b0;
          lui_q   <= 1'b0;
          jump_q  <= 1'b0;
          beq_q   <= 1'b0;
          bne_q   <= 1'b0;
          bge_q   <= 1'b0;
          blt_q   <= 1'b0;
          state_q <= StFetch;
        end
        StTrap: illegal_q <= 1'b1;
        default: state_q <= StTrap;
      endcase
    end
  end

  assign imem.imem_req  = (state_q == StFetch);
  assign imem.imem_addr = pc_q;

  assign read_reg_num1  = rs1_q;
  assign read_reg_num2  = rs2_q;
  assign write_reg_num1 = rd_q;
  assign alu_control    = alu_q;
  assign imm_val        = imm_q;
  assign shamt          = shamt_q;
  assign lb             = lb_q;
  assign sw             = sw_q;
  assign lui_control    = lui_q;
  assign jump           = jump_q;
  assign beq_control    = beq_q;
  assign bne_control    = bne_q;
  assign bgeq_control   = bge_q;
  assign blt_control    = blt_q;
  assign imm_val_lui    = imm_lui_q;
  assign imm_val_jump   = imm_jump_q;
  assign return_address = ret_q;
  assign pc             = pc_q;
  assign illegal        = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: an imem model serves instructions while a
// queue of expected fetch addresses tracks the PC flow.
module tb_control_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] I_ADDI = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_BEQ  = 32'h0020_8463;  // beq x1,x2,+8
  localparam logic [31:0] I_NOP  = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] I_JAL  = 32'hFFDF_F0EF;  // jal x1,-4
  localparam logic [31:0] I_SW   = 32'h0020_A1A3;  // sw x2,3(x1)
  localparam logic [31:0] I_LUI  = 32'hABCD_E2B7;  // lui x5,0xABCDE
  localparam logic [31:0] I_BAD  = 32'h0000_007F;

  logic        clk;
  logic        rst;
  logic [4:0]  read_reg_num1, read_reg_num2, write_reg_num1;
  logic [5:0]  alu_control;
  logic [31:0] imm_val, imm_val_lui, imm_val_jump, return_address, pc;
  logic [3:0]  shamt;
  logic        lb, sw, lui_control, jump;
  logic        beq_control, bne_control, bgeq_control, blt_control;
  logic        beq, bneq, bge, blt;
  logic        illegal;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] got_addr;
  logic [31:0] want;

  control_sequencer_if bus ();

  control_sequencer #(
    .RESET_PC (RST_PC),
    .PC_STEP  (32'd4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (bus),
    .read_reg_num1  (read_reg_num1),
    .read_reg_num2  (read_reg_num2),
    .write_reg_num1 (write_reg_num1),
    .alu_control    (alu_control),
    .imm_val        (imm_val),
    .shamt          (shamt),
    .lb             (lb),
    .sw             (sw),
    .lui_control    (lui_control),
    .jump           (jump),
    .beq_control    (beq_control),
    .bne_control    (bne_control),
    .bgeq_control   (bgeq_control),
    .blt_control    (blt_control),
    .imm_val_lui    (imm_val_lui),
    .imm_val_jump   (imm_val_jump),
    .return_address (return_address),
    .beq            (beq),
    .bneq           (bneq),
    .bge            (bge),
    .blt            (blt),
    .pc             (pc),
    .illegal        (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for a fetch, serves instr after `waits` cycles, returns in EXEC.
  task automatic issue(input logic [31:0] instr, input int waits, output logic [31:0] addr);
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    addr = (bus.imem_req === 1'b1) ? bus.imem_addr : 32'hxxxx_xxxx;
    repeat (waits) @(negedge clk);
    bus.imem_valid = 1'b1;
    bus.imem_instr = instr;
    @(negedge clk);
    bus.imem_valid = 1'b0;
    bus.imem_instr = 32'h0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pop_exp();
    return (exp_addr.size() > 0) ? exp_addr.pop_front() : 32'hDEAD_BEEF;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_instr = 32'h0;
    {beq, bneq, bge, blt} = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_addr.delete();
    exp_addr.push_back(RST_PC);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_instr = 32'h0;
    {beq, bneq, bge, blt} = 4'b0000;
    repeat (2) @(negedge clk);
    n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    n_checks++;
    if ({lb, sw, lui_control, jump, beq_control, bne_control, bgeq_control, blt_control} !== 8'h00) begin
      n_fail++; $display("FAIL reset_strobes: got nonzero strobes want 0");
    end
    n_checks++; if (alu_control !== 6'd0) begin n_fail++; $display("FAIL reset_alu: got %0d want 0", alu_control); end
    n_checks++;
    if ({imm_val, imm_val_jump, write_reg_num1} !== '0) begin
      n_fail++; $display("FAIL reset_fields: got imm %h jimm %h rd %0d want 0", imm_val, imm_val_jump, write_reg_num1);
    end
    rst = 1'b1;
    exp_addr.delete();
    exp_addr.push_back(RST_PC);
  endtask

  task automatic test_addi();
    issue(I_ADDI, 2, got_addr);
    want = pop_exp();
    n_checks++; if (got_addr !== want) begin n_fail++; $display("FAIL addi_fetch_addr: got %h want %h", got_addr, want); end
    n_checks++; if (alu_control !== 6'd10) begin n_fail++; $display("FAIL addi_alu: got %0d want 10", alu_control); end
    n_checks++; if (imm_val !== 32'd5) begin n_fail++; $display("FAIL addi_imm: got %h want 5", imm_val); end
    n_checks++; if (write_reg_num1 !== 5'd1) begin n_fail++; $display("FAIL addi_rd: got %0d want 1", write_reg_num1); end
    exp_addr.push_back(32'd4);
    @(negedge clk);
    n_checks++; if (pc !== 32'd4) begin n_fail++; $display("FAIL addi_pc: got %h want 4", pc); end
  endtask

  task automatic test_branch_taken_and_jal();
    issue(I_BEQ, 0, got_addr);
    want = pop_exp();
    n_checks++; if (got_addr !== want) begin n_fail++; $display("FAIL beq_fetch_addr: got %h want %h", got_addr, want); end
    n_checks++; if (beq_control !== 1'b1) begin n_fail++; $display("FAIL beq_qual_exec: got %b want 1", beq_control); end
    n_checks++; if (alu_control !== 6'd20) begin n_fail++; $display("FAIL beq_alu: got %0d want 20", alu_control); end
    beq = 1'b1;
    exp_addr.push_back(32'd12);
    @(negedge clk);
    beq = 1'b0;
    n_checks++; if (beq_control !== 1'b0) begin n_fail++; $display("FAIL beq_qual_after: got %b want 0", beq_control); end
    issue(I_NOP, 0, got_addr);
    want = pop_exp();
    n_checks++; if (got_addr !== want) begin n_fail++; $display("FAIL beq_taken_target: got %h want %h", got_addr, want); end
    exp_addr.push_back(32'd16);
    @(negedge clk);
    issue(I_JAL, 0, got_addr);
    want = pop_exp();
    n_checks++; if (got_addr !== want) begin n_fail++; $display("FAIL jal_fetch_addr: got %h want %h", got_addr, want); end
    n_checks++; if (jump !== 1'b1) begin n_fail++; $display("FAIL jal_strobe_exec: got %b want 1", jump); end
    n_checks++; if (return_address !== 32'd20) begin n_fail++; $display("FAIL jal_ret: got %h want 20", return_address); end
    n_checks++; if (imm_val_jump !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL jal_imm: got %h want fffffffc", imm_val_jump); end
    exp_addr.push_back(32'd12);
    @(negedge clk);
    n_checks++; if (jump !== 1'b0) begin n_fail++; $display("FAIL jal_strobe_after: got %b want 0", jump); end
    issue(I_NOP, 0, got_addr);
    want = pop_exp();
    n_checks++; if (got_addr !== want) begin n_fail++; $display("FAIL jal_target: got %h want %h", got_addr, want); end
  endtask

  // Unmatched flags are driven high to show only the qualified flag is honoured.
  task automatic test_branch_not_taken();
    do_reset();
    issue(I_NOP, 0, got_addr);
    want = pop_exp();
    n_checks++; if (got_addr !== want) begin n_fail++; $display("FAIL nt_first_fetch: got %h want %h", got_addr, want); end
    exp_addr.push_back(32'd4);
    @(negedge clk);
    issue(I_BEQ, 0, got_addr);
    want = pop_exp();
    n_checks++; if (got_addr !== want) begin n_fail++; $display("FAIL nt_beq_fetch: got %h want %h", got_addr, want); end
    {beq, bneq, bge, blt} = 4'b0111;
    exp_addr.push_back(32'd8);
    @(negedge clk);
    {beq, bneq, bge, blt} = 4'b0000;
    issue(I_NOP, 0, got_addr);
    want = pop_exp();
    n_checks++; if (got_addr !== want) begin n_fail++; $display("FAIL nt_target: got %h want %h", got_addr, want); end
  endtask

  task automatic test_store_lui();
    do_reset();
    issue(I_SW, 0, got_addr);
    want = pop_exp();
    n_checks++; if (got_addr !== want) begin n_fail++; $display("FAIL sw_fetch_addr: got %h want %h", got_addr, want); end
    n_checks++; if (sw !== 1'b1 || lb !== 1'b0) begin n_fail++; $display("FAIL sw_strobes: got sw=%b lb=%b want sw=1 lb=0", sw, lb); end
    n_checks++; if (imm_val !== 32'd3) begin n_fail++; $display("FAIL sw_imm: got %h want 3", imm_val); end
    exp_addr.push_back(32'd4);
    @(negedge clk);
    n_checks++; if (sw !== 1'b0) begin n_fail++; $display("FAIL sw_after: got %b want 0", sw); end
    issue(I_LUI, 0, got_addr);
    want = pop_exp();
    n_checks++; if (got_addr !== want) begin n_fail++; $display("FAIL lui_fetch_addr: got %h want %h", got_addr, want); end
    n_checks++; if (lui_control !== 1'b1) begin n_fail++; $display("FAIL lui_strobe_exec: got %b want 1", lui_control); end
    n_checks++; if (imm_val_lui !== 32'hABCD_E000) begin n_fail++; $display("FAIL lui_imm: got %h want abcde000", imm_val_lui); end
    n_checks++; if (write_reg_num1 !== 5'd5) begin n_fail++; $display("FAIL lui_rd: got %0d want 5", write_reg_num1); end
    exp_addr.push_back(32'd8);
    @(negedge clk);
    n_checks++; if (lui_control !== 1'b0) begin n_fail++; $display("FAIL lui_after: got %b want 0", lui_control); end
    issue(I_NOP, 0, got_addr);
    want = pop_exp();
    n_checks++; if (got_addr !== want) begin n_fail++; $display("FAIL lui_next_fetch: got %h want %h", got_addr, want); end
  endtask

  task automatic test_illegal();
    int req_seen = 0;
    do_reset();
    issue(I_BAD, 0, got_addr);
    want = pop_exp();
    n_checks++; if (got_addr !== want) begin n_fail++; $display("FAIL ill_fetch_addr: got %h want %h", got_addr, want); end
    n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag: got %b want 1", illegal); end
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req !== 1'b0) req_seen++;
      @(negedge clk);
    end
    n_checks++; if (req_seen != 0) begin n_fail++; $display("FAIL ill_no_fetch: got %0d req cycles want 0", req_seen); end
    rst = 1'b0;
    #1;
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL ill_cleared: got %b want 0", illegal); end
    n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL ill_reset_pc: got %h want %h", pc, RST_PC); end
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    issue(I_NOP, 0, got_addr);
    want = pop_exp();
    n_checks++; if (got_addr !== want) begin n_fail++; $display("FAIL rx_first_fetch: got %h want %h", got_addr, want); end
    exp_addr.push_back(32'd4);
    @(negedge clk);
    issue(I_SW, 0, got_addr);
    want = pop_exp();
    n_checks++; if (sw !== 1'b1) begin n_fail++; $display("FAIL rx_sw_exec: got %b want 1", sw); end
    rst = 1'b0;
    #1;
    n_checks++; if (sw !== 1'b0) begin n_fail++; $display("FAIL rx_sw_async_drop: got %b want 0", sw); end
    @(negedge clk);
    rst = 1'b1;
    exp_addr.delete();
    exp_addr.push_back(RST_PC);
    issue(I_NOP, 0, got_addr);
    want = pop_exp();
    n_checks++; if (got_addr !== want) begin n_fail++; $display("FAIL rx_refetch: got %h want %h", got_addr, want); end
  endtask

  initial begin
    rst = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_instr = 32'h0;
    {beq, bneq, bge, blt} = 4'b0000;
    test_reset();
    test_addi();
    test_branch_taken_and_jal();
    test_branch_not_taken();
    test_store_lui();
    test_illegal();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
